// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - PRBS-26 receive checker with lock/loss tracking and error counting

module lfsr_checker #(
  parameter int N         = 26,
  parameter int LOCK_CNT  = 32,
  parameter int ERR_LIMIT = 4,
  parameter int WIN       = 64
) (
  input  logic         clk,
  input  logic         r,
  input  logic         load,
  input  logic [3:0]   s,
  input  logic         din,
  input  logic         din_valid,
  output logic [N-1:0] q,
  output logic         locked,
  output logic         lost,
  output logic         bit_err,
  output logic [15:0]  err_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HUNT   = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  localparam logic [1:0] LOST   = 2'd3;

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int EW = $clog2(ERR_LIMIT + 1);

  // Galois taps for x^26+x^6+x^2+x+1: feedback folds into bits 1, 2 and 6.
  localparam logic [N-1:0] TAPS = N'(7'b1000110);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  q_q, q_d;
  logic [MW-1:0] match_cnt_q, match_cnt_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [EW-1:0] win_err_q, win_err_d;
  logic [15:0]   err_count_q, err_count_d;
  logic          bit_err_q, bit_err_d;

  logic          fb;
  logic [N-1:0]  q_adv;
  logic          step;
  logic          mismatch;
  logic [3:0]    seed;
  logic [EW-1:0] win_err_inc;

  // Next-state logic: seed load, LFSR advance, bit compare and lock FSM.
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_count_d = err_count_q;
    bit_err_d   = 1'b0;

    fb          = q_q[N-1];
    q_adv       = {q_q[N-2:0], fb} ^ (TAPS & {N{fb}});
    step        = din_valid & (state_q != IDLE);
    mismatch    = step & ~load & (din != fb);
    seed        = (s == 4'd0) ? 4'b0001 : s;
    win_err_inc = win_err_q + EW'(mismatch);

    if (load) begin
      // A zero seed would lock the LFSR at all-zeros, so substitute 1.
      q_d         = {{(N-4){1'b0}}, seed};
      match_cnt_d = '0;
      win_cnt_d   = '0;
      win_err_d   = '0;
      err_count_d = '0;
      state_d     = HUNT;
    end else if (step) begin
      q_d       = q_adv;
      bit_err_d = mismatch;
      if (mismatch && (err_count_q != 16'hFFFF)) begin
        err_count_d = err_count_q + 16'd1;
      end

      case (state_q)
        HUNT: begin
          if (mismatch) begin
            match_cnt_d = '0;
          end else if (match_cnt_q + MW'(1) == MW'(LOCK_CNT)) begin
            match_cnt_d = '0;
            win_cnt_d   = '0;
            win_err_d   = '0;
            state_d     = LOCKED;
          end else begin
            match_cnt_d = match_cnt_q + MW'(1);
          end
        end
        LOCKED: begin
          // The wrapping bit still belongs to the ending window.
          if (win_err_inc == EW'(ERR_LIMIT)) begin
            state_d = LOST;
          end
          if (win_cnt_q == WW'(WIN - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WW'(1);
            win_err_d = win_err_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State registers with synchronous active-high reset taking priority.
  always_ff @(posedge clk) begin
    if (r) begin
      state_q     <= IDLE;
      q_q         <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_count_q <= '0;
      bit_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_count_q <= err_count_d;
      bit_err_q   <= bit_err_d;
    end
  end

  assign q         = q_q;
  assign locked    = (state_q == LOCKED);
  assign lost      = (state_q == LOST);
  assign bit_err   = bit_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - self-checking bench for lfsr_checker against a polynomial reference model

module tb_lfsr_checker;

  localparam int N         = 26;
  localparam int LOCK_CNT  = 32;
  localparam int ERR_LIMIT = 4;
  localparam int WIN       = 64;

  logic         clk = 1'b0;
  logic         r = 1'b1;
  logic         load = 1'b0;
  logic [3:0]   s = 4'd0;
  logic         din = 1'b0;
  logic         din_valid = 1'b0;
  logic [N-1:0] q;
  logic         locked;
  logic         lost;
  logic         bit_err;
  logic [15:0]  err_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: LFSR state as a GF(2) polynomial, multiplied by x mod p(x).
  longint m_q;
  int     m_mode;     // 0 idle, 1 hunting, 2 locked, 3 lost
  int     m_run;      // consecutive good bits while hunting
  int     m_pos;      // bit index inside the current window
  int     m_werr;     // errors seen in the current window
  int     m_errs;     // total mismatches since load, saturating
  int     m_biterr;

  lfsr_checker #(.N(N), .LOCK_CNT(LOCK_CNT), .ERR_LIMIT(ERR_LIMIT), .WIN(WIN)) dut (
    .clk(clk), .r(r), .load(load), .s(s), .din(din), .din_valid(din_valid),
    .q(q), .locked(locked), .lost(lost), .bit_err(bit_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic longint mulx(input longint x);
    longint y;
    y = x << 1;
    if (((y >> 26) & 1) != 0) y = y ^ 64'h4000047;
    return y;
  endfunction

  function automatic bit exp_bit();
    return bit'((m_q >> 25) & 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit rr, input bit ld, input logic [3:0] sd, input bit d, input bit v);
    bit mis;
    if (rr) begin
      m_q = 0; m_mode = 0; m_run = 0; m_pos = 0; m_werr = 0; m_errs = 0; m_biterr = 0;
    end else if (ld) begin
      m_q = (sd == 0) ? 1 : longint'(sd);
      m_mode = 1; m_run = 0; m_pos = 0; m_werr = 0; m_errs = 0; m_biterr = 0;
    end else if (v && m_mode != 0) begin
      mis = (d != exp_bit());
      m_q = mulx(m_q);
      m_biterr = int'(mis);
      if (mis && m_errs < 65535) m_errs++;
      if (m_mode == 1) begin
        m_run = mis ? 0 : m_run + 1;
        if (m_run == LOCK_CNT) begin
          m_mode = 2; m_pos = 0; m_werr = 0; m_run = 0;
        end
      end else if (m_mode == 2) begin
        m_werr += int'(mis);
        if (m_werr == ERR_LIMIT) m_mode = 3;
        m_pos++;
        if (m_pos == WIN) begin
          m_pos = 0; m_werr = 0;
        end
      end
    end else begin
      m_biterr = 0;
    end
  endtask

  task automatic compare_all();
    check("q", 32'(q), 32'(m_q));
    check("locked", 32'(locked), 32'(m_mode == 2));
    check("lost", 32'(lost), 32'(m_mode == 3));
    check("bit_err", 32'(bit_err), 32'(m_biterr));
    check("err_count", 32'(err_count), 32'(m_errs));
  endtask

  task automatic tick(input bit rr, input bit ld, input logic [3:0] sd, input bit d, input bit v);
    r = rr; load = ld; s = sd; din = d; din_valid = v;
    @(posedge clk);
    model_step(rr, ld, sd, d, v);
    #1;
    compare_all();
  endtask

  task automatic send(input bit flip);
    tick(1'b0, 1'b0, 4'd0, exp_bit() ^ flip, 1'b1);
  endtask

  task automatic send_good(input int n);
    for (int i = 0; i < n; i++) send(1'b0);
  endtask

  int pulses;
  int f1, f2, f3, f4;

  initial begin
    model_step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

    // Reset state, then valid data in IDLE is ignored.
    tick(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
    check("reset_q", 32'(q), 32'd0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 4'd0, 1'(i), 1'b1);
    check("idle_q_hold", 32'(q), 32'd0);

    // Clean stream from seed 1: lock after bit 32, no errors.
    tick(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
    check("seed1_q", 32'(q), 32'd1);
    pulses = 0;
    for (int i = 0; i < LOCK_CNT - 1; i++) begin
      send(1'b0);
      pulses += int'(bit_err);
    end
    check("no_lock_at_31", 32'(locked), 32'd0);
    send(1'b0);
    pulses += int'(bit_err);
    check("lock_at_32", 32'(locked), 32'd1);
    check("clean_err_count", 32'(err_count), 32'd0);
    check("clean_no_pulses", 32'(pulses), 32'd0);

    // Three flips inside one window keep lock; a fourth loses it.
    f1 = $urandom_range(0, 15);
    f2 = $urandom_range(16, 31);
    f3 = $urandom_range(32, 47);
    f4 = $urandom_range(50, 60);
    pulses = 0;
    for (int i = 0; i < f4; i++) begin
      send(i == f1 || i == f2 || i == f3);
      pulses += int'(bit_err);
    end
    check("three_pulses", 32'(pulses), 32'd3);
    check("three_err_count", 32'(err_count), 32'd3);
    check("three_still_locked", 32'(locked), 32'd1);
    send(1'b1);
    check("fourth_lost", 32'(lost), 32'd1);
    send_good(40);
    check("lost_sticky", 32'(lost), 32'd1);

    // Errors straddling a window boundary do not lose lock.
    tick(1'b0, 1'b1, 4'($urandom_range(1, 15)), 1'b0, 1'b0);
    send_good(LOCK_CNT);
    f4 = $urandom_range(0, 7);
    for (int i = 0; i < WIN + 20; i++) send(i == 61 || i == 62 || i == 63 || i == WIN + f4);
    check("straddle_locked", 32'(locked), 32'd1);
    check("straddle_err_count", 32'(err_count), 32'd4);

    // A mismatch on bit 20 while hunting delays lock to bit 52.
    tick(1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
    for (int i = 0; i < 51; i++) send(i == 19);
    check("hunt_restart_no_lock", 32'(locked), 32'd0);
    send(1'b0);
    check("hunt_restart_lock", 32'(locked), 32'd1);

    // Zero seed, load beating din_valid, reset while locked.
    tick(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    check("seed0_q", 32'(q), 32'd1);
    tick(1'b0, 1'b1, 4'd9, 1'b1, 1'b1);
    check("load_over_valid_q", 32'(q), 32'd9);
    tick(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check("no_valid_hold", 32'(q), 32'd9);
    send_good(LOCK_CNT);
    tick(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    send(1'b1);
    check("rst_idle_no_biterr", 32'(bit_err), 32'd0);

    // Randomised traffic: seeds, flips, gaps, loads and occasional resets.
    tick(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        tick(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      end else if ($urandom_range(0, 199) == 0) begin
        tick(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 3) == 0) begin
        tick(1'b0, 1'b0, 4'd0, 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        send($urandom_range(0, 59) == 0);
      end
    end

    // Inverted stream drives err_count into saturation.
    tick(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) send(1'b1);
    check("sat_err_count", 32'(err_count), 32'h0000FFFF);
    check("sat_lost_or_hunt", 32'(locked), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter N, default 26: LFSR length in bits, matching the team's 26-bit generator.
REQ-002 Parameter LOCK_CNT, default 32: consecutive matching bits needed to declare lock.
REQ-003 Parameter ERR_LIMIT, default 4: errors within one window that cause loss of lock.
REQ-004 Parameter WIN, default 64: error-window length in valid bits.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 r  input  1  reset, synchronous and active-high.
REQ-007 load  input  1  seed-load strobe; must be held 1 for one cycle.
REQ-008 s  input  4  seed written to q[3:0] on load.
REQ-009 din  input  1  received serial PRBS bit.
REQ-010 din_valid  input  1  din is sampled in this cycle.
REQ-011 q  output  N  local reference LFSR state.
REQ-012 locked  output  1  high while in state LOCKED.
REQ-013 lost  output  1  high while in state LOST.
REQ-014 bit_err  output  1  one-cycle pulse flagging a mismatched bit.
REQ-015 err_count  output  16  saturating count of mismatches since the last load.

Function
REQ-016 Polynomial x^26+x^6+x^2+x+1, Galois form; expected bit = q[N-1] before advance.
REQ-017 Advance: fb=q[N-1]; q[0]<=fb; q[1]<=q[0]^fb; q[2]<=q[1]^fb; q[6]<=q[5]^fb; every other q[i]<=q[i-1].
REQ-018 q advances exactly once per cycle with din_valid=1 and load=0, in states HUNT, LOCKED and LOST; otherwise q holds.
REQ-019 States: IDLE, HUNT, LOCKED, LOST; locked and lost are pure decodes of the registered state.
REQ-020 load=1 (any state): q<={0,s}, except s=0 loads {0,4'b0001}; match and window counters, window error count and err_count cleared; next state HUNT.
REQ-021 load has priority over din_valid in the same cycle; that din is ignored and q does not advance.
REQ-022 Mismatch = din_valid & ~load & (din != q[N-1]) in HUNT, LOCKED or LOST; bit_err is registered and goes high the cycle after the mismatched bit, for one cycle.
REQ-023 err_count increments on every mismatch, saturates at 16'hFFFF and clears only on reset or load.
REQ-024 HUNT: a match increments the match counter and a mismatch clears it; LOCKED is entered on the valid bit that brings the counter to LOCK_CNT.
REQ-025 Entering LOCKED clears the window counter and the window error count.
REQ-026 LOCKED: the window counter counts valid bits 0..WIN-1 and wraps; each mismatch increments the window error count.
REQ-027 LOCKED: on the bit that brings the window error count to ERR_LIMIT, next state is LOST.
REQ-028 Window wrap: the bit on which the counter wraps is evaluated in the ending window; the window error count is cleared after that evaluation.
REQ-029 LOST is sticky until load or reset; q keeps advancing and err_count keeps counting in LOST.
REQ-030 IDLE: din and din_valid are ignored; bit_err=0; q holds.

Reset
REQ-031 While r=1 at a clock edge: state<=IDLE, q<=0, all counters 0, err_count=0, bit_err=0, locked=0, lost=0.
REQ-032 r has priority over load and din_valid.
REQ-033 Reset asserted mid-stream gives the same result as REQ-031; a load is then required before checking resumes.

Verification
REQ-034 Reset, load s=4'b0001, feed the correct stream (25 zeros then 1, continuing from REQ-017) -> locked rises on the cycle after bit 32; err_count=0; bit_err never asserts.
REQ-035 Locked; flip 3 bits within one 64-bit window -> three bit_err pulses, err_count=3, locked stays 1. Flip a 4th bit in that window -> lost=1 the cycle after the 4th flip.
REQ-036 Locked; flip 3 bits late in one window and 1 bit early in the next -> locked stays 1, err_count=4.
REQ-037 In HUNT, flip bit 20 -> match counter restarts; lock occurs the cycle after bit 52, not bit 32.
REQ-038 load s=0 -> q=26'h0000001; load asserted together with din_valid -> q not advanced; reset pulse while LOCKED -> IDLE and all outputs 0 the next cycle.
REQ-039 Force more than 65535 mismatches (inverted stream) -> err_count holds at 16'hFFFF.
